// File: rtl/rb_arb.sv
// ---------------------------------------------------------------------------
// rb_arb -- two-requester arbiter / sequencer for the 16x16 register bank.
//
// Shares the bank's single select/write port pair between requester 0 (core
// datapath) and requester 1 (debug/load port). Each operation is one ISSUE
// cycle, in which the bank is driven and its combinational read data is
// captured, followed by one RESP cycle carrying a one-cycle ack pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rX_req/we/rs/d        request, write enable, select word, write data
//   rX_ack                one-cycle completion pulse
//   rX_a, rX_b            captured a_out/b_out, held until the next capture
//   d_in, rw_in, rs_in    drive the bank (zero outside ISSUE)
//   a_out, b_out          combinational read data from the bank
//   busy                  high in ISSUE or RESP
// ---------------------------------------------------------------------------
module rb_arb #(
   parameter int DW = 16,
   parameter int SW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [SW-1:0] r0_rs,
   input  logic [DW-1:0] r0_d,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [SW-1:0] r1_rs,
   input  logic [DW-1:0] r1_d,
   output logic          r0_ack,
   output logic          r1_ack,
   output logic [DW-1:0] r0_a,
   output logic [DW-1:0] r0_b,
   output logic [DW-1:0] r1_a,
   output logic [DW-1:0] r1_b,
   output logic [DW-1:0] d_in,
   output logic          rw_in,
   output logic [SW-1:0] rs_in,
   input  logic [DW-1:0] a_out,
   input  logic [DW-1:0] b_out,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_prio;    // requester favoured on a tie in IDLE
   logic          r_gnt;     // requester owning the current operation
   logic          r_we;
   logic [SW-1:0] r_rs;
   logic [DW-1:0] r_d;
   logic [DW-1:0] r_r0_a;
   logic [DW-1:0] r_r0_b;
   logic [DW-1:0] r_r1_a;
   logic [DW-1:0] r_r1_b;

   state_t        w_next_state;
   logic          w_load;    // latch a new operation this cycle
   logic          w_win;     // requester being granted when w_load=1

   // Next-state and grant selection.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      w_next_state = r_state;
      w_load       = 1'b0;
      w_win        = r_gnt;
      case (r_state)
         S_IDLE: begin
            if (r0_req || r1_req) begin
               w_load       = 1'b1;
               // Lone requester wins; on a tie the pointer decides.
               w_win        = r1_req & (~r0_req | r_prio);
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next_state = S_RESP;
         end
         S_RESP: begin
            // Only the other requester is looked at here: the acked one's
            // req still belongs to the operation just completed.
            if (r_gnt ? r0_req : r1_req) begin
               w_load       = 1'b1;
               w_win        = ~r_gnt;
               w_next_state = S_ISSUE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_gnt   <= 1'b0;
         r_we    <= 1'b0;
         r_rs    <= '0;
         r_d     <= '0;
         r_r0_a  <= '0;
         r_r0_b  <= '0;
         r_r1_a  <= '0;
         r_r1_b  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load) begin
            r_gnt  <= w_win;
            r_prio <= ~w_win;
            r_we   <= w_win ? r1_we : r0_we;
            r_rs   <= w_win ? r1_rs : r0_rs;
            r_d    <= w_win ? r1_d  : r0_d;
         end
         // Capture at the end of ISSUE; for a write this is the pre-write
         // value because the bank commits on this same edge.
         if (r_state == S_ISSUE) begin
            if (r_gnt) begin
               r_r1_a <= a_out;
               r_r1_b <= b_out;
            end else begin
               r_r0_a <= a_out;
               r_r0_b <= b_out;
            end
         end
      end
   end

   // Bank drive and acks decode straight from registered state, so an
   // asynchronous reset removes rw_in and the acks immediately.
   assign rw_in  = (r_state == S_ISSUE) & r_we;
   assign d_in   = ((r_state == S_ISSUE) && r_we) ? r_d : '0;
   assign rs_in  = (r_state == S_ISSUE) ? r_rs : '0;
   assign r0_ack = (r_state == S_RESP) & ~r_gnt;
   assign r1_ack = (r_state == S_RESP) &  r_gnt;
   assign busy   = (r_state != S_IDLE);

   assign r0_a = r_r0_a;
   assign r0_b = r_r0_b;
   assign r1_a = r_r1_a;
   assign r1_b = r_r1_b;

   // A request must be held until its ack.
   a_r0_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (r0_req && !r0_ack) |=> r0_req);
   a_r1_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (r1_req && !r1_ack) |=> r1_req);

endmodule
